// File: rtl/qfix_pkg.sv
// Shared types and defaults for the signed fixed-point add/sub/accumulate unit.
// Build option: QFIX_SAT_EN selects saturating results (default: wrapping).
package qfix_pkg;

  typedef enum logic [1:0] {
    QFIX_ADD = 2'b00,
    QFIX_SUB = 2'b01,
    QFIX_ACC = 2'b10,
    QFIX_CLR = 2'b11
  } qfix_op_e;

  localparam int QFIX_INT_BITS  = 8;
  localparam int QFIX_FRAC_BITS = 8;

endpackage

// File: rtl/qfix_sat_add.sv
// Combinational W-bit signed add/subtract with overflow detection.
// Build option: QFIX_SAT_EN clamps overflowed results to the signed extremes;
// without it the result wraps to the low W bits.
module qfix_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] res,
  output logic         ovf
);

  logic [W:0] ext_a;
  logic [W:0] ext_b;
  logic [W:0] sum;

  // One guard bit above the sign makes signed overflow a simple bit compare.
  always_comb begin
    ext_a = {a[W-1], a};
    ext_b = {b[W-1], b};
    sum   = sub ? (ext_a - ext_b) : (ext_a + ext_b);
    ovf   = sum[W] ^ sum[W-1];
`ifdef QFIX_SAT_EN
    // The guard bit holds the true sign, so it picks which extreme to clamp to.
    if (ovf) res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else     res = sum[W-1:0];
`else
    res = sum[W-1:0];
`endif
  end

endmodule

// File: rtl/qfix_addsub_pipe.sv
// Two-stage pipelined signed Qm.n add/sub/accumulate unit with valid/ready
// handshake on both sides and an internal accumulator.
// Build option: QFIX_SAT_EN (saturation, handled inside qfix_sat_add).
module qfix_addsub_pipe
  import qfix_pkg::*;
#(
  parameter int INT_BITS  = QFIX_INT_BITS,
  parameter int FRAC_BITS = QFIX_FRAC_BITS,
  parameter int W         = INT_BITS + FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] operand1,
  input  logic [W-1:0] operand2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow
);

  logic         s1_valid_q, s1_valid_d;
  qfix_op_e     s1_op_q, s1_op_d;
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;

  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] result_q, result_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] acc_q, acc_d;

  logic         in_fire;
  logic         s2_load;
  logic [W-1:0] add_a, add_b, add_res;
  logic         add_sub, add_ovf;

  // Handshake: S1 drains whenever S2 is empty or S2 is being consumed.
  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    in_fire  = in_valid && in_ready;
  end

  // Adder operand selection: ACC adds operand1 onto the running accumulator.
  always_comb begin
    add_a   = (s1_op_q == QFIX_ACC) ? acc_q  : s1_a_q;
    add_b   = (s1_op_q == QFIX_ACC) ? s1_a_q : s1_b_q;
    add_sub = (s1_op_q == QFIX_SUB);
  end

  qfix_sat_add #(.W(W)) u_add (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .res (add_res),
    .ovf (add_ovf)
  );

  // S1 next state: capture on accept, otherwise empty out once S2 takes it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (s2_load) s1_valid_d = 1'b0;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = qfix_op_e'(op);
      s1_a_d     = operand1;
      s1_b_d     = operand2;
    end
  end

  // S2 next state: result/overflow only change on load, so they hold while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q && !out_ready;
    result_d   = result_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      case (s1_op_q)
        QFIX_CLR: begin
          result_d = '0;
          ovf_d    = 1'b0;
          acc_d    = '0;
        end
        QFIX_ACC: begin
          result_d = add_res;
          ovf_d    = add_ovf;
          acc_d    = add_res;
        end
        default: begin
          result_d = add_res;
          ovf_d    = add_ovf;
        end
      endcase
    end
  end

  // Pipeline and accumulator registers; reset drops any in-flight beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= QFIX_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_qfix_addsub_pipe.sv
// Self-checking bench for qfix_addsub_pipe: directed cases plus randomized
// traffic scored against an integer-arithmetic reference model.
module tb_qfix_addsub_pipe;

  localparam int W    = 16;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_CLR = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         overflow;

  qfix_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         o;
  } exp_t;

  exp_t         expq[$];
  int           macc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic         held_v = 1'b0;
  logic [W:0]   held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then wrap or clamp into W bits.
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t e);
    int x, y, s;
    x = $signed(a);
    y = $signed(b);
    if (o == OP_CLR) begin
      macc = 0;
      e.r  = '0;
      e.o  = 1'b0;
      return;
    end
    case (o)
      OP_ADD:  s = x + y;
      OP_SUB:  s = x - y;
      default: s = macc + x;
    endcase
    e.o = (s > MAXV) || (s < MINV);
`ifdef QFIX_SAT_EN
    if (s > MAXV)      s = MAXV;
    else if (s < MINV) s = MINV;
`endif
    e.r = s[W-1:0];
    if (o == OP_ACC) macc = $signed(e.r);
  endtask

  // One clock cycle: drive inputs, score any output transfer, log any input
  // transfer, then advance to just after the next rising edge.
  task automatic cyc(input logic v, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic rdy);
    exp_t e;
    in_valid = v; op = o; operand1 = a; operand2 = b; out_ready = rdy;
    #1;
    if (held_v) begin
      chk("hold_stable", {15'd0, out_valid, overflow, result}, {15'd0, 1'b1, held});
    end
    held_v = out_valid && !out_ready;
    held   = {overflow, result};
    if (out_valid && out_ready) begin
      vectors++;
      assert (expq.size() != 0) else begin
        miscompares++;
        $error("FAIL spurious_out observed=%h expected=none", result);
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("result", result, e.r);
        chk("overflow", overflow, e.o);
      end
    end
    if (v && in_ready) begin
      model(o, a, b, e);
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Single beat into an idle pipe: check latency and the literal expected value.
  task automatic direct(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic eo);
    cyc(1'b1, o, a, b, 1'b1);
    chk({tag, "_lat_early"}, out_valid, 1'b0);
    cyc(1'b0, 2'b00, '0, '0, 1'b1);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_ovf"}, overflow, eo);
    cyc(1'b0, 2'b00, '0, '0, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Basic arithmetic
    direct("add", OP_ADD, 16'h0108, 16'h0380, 16'h0488, 1'b0);
    direct("sub", OP_SUB, 16'h0402, 16'h0008, 16'h03FA, 1'b0);
    direct("subneg", OP_SUB, 16'h0008, 16'h0402, 16'hFC06, 1'b0);
`ifdef QFIX_SAT_EN
    direct("ovf_pos", OP_ADD, 16'h7F00, 16'h0200, 16'h7FFF, 1'b1);
    direct("ovf_neg", OP_SUB, 16'h8000, 16'h0100, 16'h8000, 1'b1);
`else
    direct("ovf_pos", OP_ADD, 16'h7F00, 16'h0200, 16'h8100, 1'b1);
    direct("ovf_neg", OP_SUB, 16'h8000, 16'h0100, 16'h7F00, 1'b1);
`endif

    // Accumulate chain: CLR then three back-to-back ACC beats
    cyc(1'b1, OP_CLR, 16'h1234, '0, 1'b1);
    cyc(1'b1, OP_ACC, 16'h0100, '0, 1'b1);
    chk("acc0", result, 16'h0000);
    cyc(1'b1, OP_ACC, 16'h0100, '0, 1'b1);
    chk("acc1", result, 16'h0100);
    cyc(1'b1, OP_ACC, 16'h0100, '0, 1'b1);
    chk("acc2", result, 16'h0200);
    cyc(1'b0, OP_ADD, '0, '0, 1'b1);
    chk("acc3", result, 16'h0300);
    chk("acc3_valid", out_valid, 1'b1);
    cyc(1'b0, OP_ADD, '0, '0, 1'b1);

    // Backpressure: two accepts fill the pipe, third waits for release
    cyc(1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b0);
    chk("bp_ready1", in_ready, 1'b1);
    cyc(1'b1, OP_ADD, 16'h0010, 16'h0010, 1'b0);
    chk("bp_ready_full", in_ready, 1'b0);
    cyc(1'b1, OP_ADD, 16'h0100, 16'h0100, 1'b0);
    cyc(1'b1, OP_ADD, 16'h0100, 16'h0100, 1'b0);
    chk("bp_still_full", in_ready, 1'b0);
    cyc(1'b1, OP_ADD, 16'h0100, 16'h0100, 1'b1);
    repeat (4) cyc(1'b0, OP_ADD, '0, '0, 1'b1);
    chk("bp_drained", expq.size(), 0);

    // Reset with two beats in flight
    cyc(1'b1, OP_ACC, 16'h0500, '0, 1'b0);
    cyc(1'b1, OP_ADD, 16'h0001, 16'h0002, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    expq.delete();
    macc   = 0;
    held_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", in_ready, 1'b1);
    repeat (3) cyc(1'b0, OP_ADD, '0, '0, 1'b1);
    chk("postrst_no_stale", out_valid, 1'b0);
    direct("postrst_acc", OP_ACC, 16'h0100, '0, 16'h0100, 1'b0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), W'($urandom),
          W'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 10 && expq.size() != 0; i++) cyc(1'b0, OP_ADD, '0, '0, 1'b1);
    chk("final_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
